// File: rtl/mul_seq_32.sv
// Sequential unsigned shift-add multiplier that drives an external shared adder,
// one adder pass per multiplier bit.
module mul_seq_32 #(
  parameter int unsigned N     = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [N-1:0]     a_i,
  input  logic [N-1:0]     b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [2*N-1:0]   p_o,
  output logic [N-1:0]     add_a_o,
  output logic [N-1:0]     add_b_o,
  output logic             add_c0_o,
  input  logic [N:0]       add_s_i
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic [N-1:0]       acc_hi_q, acc_hi_d;
  logic [N-1:0]       acc_lo_q, acc_lo_d;
  logic [N-1:0]       mcand_q, mcand_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*N-1:0]     p_q, p_d;

  logic               last_iter;
  logic [2*N-1:0]     shifted;

  assign last_iter = (cnt_q == CNT_W'(N - 1));
  // Adder carry rides into the top of the accumulator so no overflow is lost.
  assign shifted   = {add_s_i, acc_lo_q[N-1:1]};

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_i) state_d = StRun;
      StRun:   if (last_iter) state_d = StDone;
      StDone:  state_d = start_i ? StRun : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs and adder drive
  always_comb begin
    busy_o   = (state_q == StRun);
    done_o   = (state_q == StDone);
    p_o      = p_q;
    add_a_o  = busy_o ? acc_hi_q : '0;
    add_b_o  = (busy_o && acc_lo_q[0]) ? mcand_q : '0;
    add_c0_o = 1'b0;
  end

  // Datapath next-state
  always_comb begin
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    mcand_d  = mcand_q;
    cnt_d    = cnt_q;
    p_d      = p_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          acc_hi_d = '0;
          acc_lo_d = b_i;
          mcand_d  = a_i;
          cnt_d    = '0;
        end
      end
      StRun: begin
        {acc_hi_d, acc_lo_d} = shifted;
        cnt_d                = cnt_q + CNT_W'(1);
        if (last_iter) p_d = shifted;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      mcand_q  <= '0;
      cnt_q    <= '0;
      p_q      <= '0;
    end else begin
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      mcand_q  <= mcand_d;
      cnt_q    <= cnt_d;
      p_q      <= p_d;
    end
  end

endmodule
